// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types, button codes and time limits for the clock controller
// Contents: state enum, debouncer press codes, field limits, wrap-increment helpers.
package clock_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_e;

   localparam logic [1:0] BTN_IDLE  = 2'b00;
   localparam logic [1:0] BTN_LONG  = 2'b01;
   localparam logic [1:0] BTN_SHORT = 2'b10;
   localparam logic [1:0] BTN_HELD  = 2'b11;

   localparam logic [4:0] HR_MAX  = 5'd23;
   localparam logic [5:0] MIN_MAX = 6'd59;
   localparam logic [5:0] SEC_MAX = 6'd59;

   // Compare-and-wrap so the sum never exceeds the field width.
   function automatic logic [4:0] inc_hr(input logic [4:0] v);
      return (v == HR_MAX) ? 5'd0 : v + 5'd1;
   endfunction

   function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max);
      return (v == max) ? 6'd0 : v + 6'd1;
   endfunction

endpackage

// File: rtl/btn_event.sv
// rtl/btn_event.sv - press-code edge detector with optional hold auto-repeat
// Ports: clk_i, rst_i (async, active high), code_i (debouncer code),
//        rpt_en_i (allow auto-repeat while held), short_o/long_o/rpt_o (one-cycle
//        registered pulses), held_o (code currently 11).
module btn_event
   import clock_pkg::*;
#(
   parameter bit REPEAT_EN  = 1'b1,
   parameter int REPEAT_CYC = 5_000_000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] code_i,
   input  logic       rpt_en_i,
   output logic       short_o,
   output logic       long_o,
   output logic       rpt_o,
   output logic       held_o
);

   logic [1:0]  prev_q;
   logic        short_q;
   logic        long_q;
   logic        rpt_q;
   logic        rpt_done_q;
   logic [31:0] rpt_cnt_q;
   logic        changed;

   // Codes linger after release, so only the first differing sample counts.
   assign changed = (code_i != prev_q);
   assign held_o  = (code_i == BTN_HELD);
   assign short_o = short_q;
   assign long_o  = long_q;
   assign rpt_o   = rpt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prev_q     <= BTN_IDLE;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         rpt_q      <= 1'b0;
         rpt_done_q <= 1'b0;
         rpt_cnt_q  <= '0;
      end else begin
         prev_q  <= code_i;
         // A release that follows auto-repeats must not add one more step.
         short_q <= changed && (code_i == BTN_SHORT) && !rpt_done_q;
         long_q  <= changed && (code_i == BTN_LONG) && !rpt_done_q;
         if (REPEAT_EN && rpt_en_i && (code_i == BTN_HELD)) begin
            if (rpt_cnt_q == 32'(REPEAT_CYC - 1)) begin
               rpt_cnt_q  <= '0;
               rpt_q      <= 1'b1;
               rpt_done_q <= 1'b1;
            end else begin
               rpt_cnt_q <= rpt_cnt_q + 32'd1;
               rpt_q     <= 1'b0;
            end
         end else begin
            rpt_cnt_q <= '0;
            rpt_q     <= 1'b0;
            // Suppression flag lives until the code leaves 11; the release
            // sample above still sees the old value.
            if (code_i != BTN_HELD) begin
               rpt_done_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-of-day keeper with hour/minute setting, blink and auto-repeat
// Ports: i_clk, i_rst (async, active high), i_mode_state/i_inc_state (debouncer codes),
//        i_sec_tick (1 Hz pulse), o_hours/o_minutes/o_seconds (time),
//        o_blank_hr/o_blank_min (blink blanking), o_setting (in a SET state).
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int BLINK_CYC  = 12_500_000,
   parameter int REPEAT_CYC = 5_000_000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_mode_state,
   input  logic [1:0] i_inc_state,
   input  logic       i_sec_tick,
   output logic [4:0] o_hours,
   output logic [5:0] o_minutes,
   output logic [5:0] o_seconds,
   output logic       o_blank_hr,
   output logic       o_blank_min,
   output logic       o_setting
);

   state_e      state_q, state_d;
   logic [4:0]  hours_q, hours_d;
   logic [5:0]  minutes_q, minutes_d;
   logic [5:0]  seconds_q, seconds_d;
   logic [31:0] blink_cnt_q, blink_cnt_d;
   logic        phase_q, phase_d;
   logic        blank_hr_q, blank_hr_d;
   logic        blank_min_q, blank_min_d;
   logic        setting_q, setting_d;

   logic mode_short, mode_long, mode_rpt;
   logic inc_short, inc_long, inc_rpt, inc_held;
   logic inc_step;

   btn_event #(.REPEAT_EN(1'b0), .REPEAT_CYC(REPEAT_CYC)) u_mode (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .code_i   (i_mode_state),
      .rpt_en_i (1'b0),
      .short_o  (mode_short),
      .long_o   (mode_long),
      .rpt_o    (mode_rpt),
      .held_o   ()
   );

   btn_event #(.REPEAT_EN(1'b1), .REPEAT_CYC(REPEAT_CYC)) u_inc (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .code_i   (i_inc_state),
      .rpt_en_i (state_q != RUN),
      .short_o  (inc_short),
      .long_o   (inc_long),
      .rpt_o    (inc_rpt),
      .held_o   (inc_held)
   );

   // Only a short press or an auto-repeat steps a field; long releases do not.
   assign inc_step = (inc_short || inc_rpt) && !inc_long && !mode_rpt;

   always_comb begin
      state_d     = state_q;
      hours_d     = hours_q;
      minutes_d   = minutes_q;
      seconds_d   = seconds_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      case (state_q)
         RUN: begin
            if (i_sec_tick) begin
               seconds_d = inc_wrap6(seconds_q, SEC_MAX);
               if (seconds_q == SEC_MAX) begin
                  minutes_d = inc_wrap6(minutes_q, MIN_MAX);
                  if (minutes_q == MIN_MAX) begin
                     hours_d = inc_hr(hours_q);
                  end
               end
            end
            if (mode_short) begin
               state_d = SET_HR;
            end else if (mode_long) begin
               seconds_d = '0;
            end
         end
         // MODE events take priority; a coincident INC event is dropped.
         SET_HR: begin
            if (mode_short) begin
               state_d = SET_MIN;
            end else if (mode_long) begin
               state_d = RUN;
            end else if (inc_step) begin
               hours_d = inc_hr(hours_q);
            end
         end
         SET_MIN: begin
            if (mode_short) begin
               state_d   = RUN;
               seconds_d = '0;
            end else if (mode_long) begin
               state_d = RUN;
            end else if (inc_step) begin
               minutes_d = inc_wrap6(minutes_q, MIN_MAX);
            end
         end
         default: state_d = RUN;
      endcase

      // Restart blink on entry so the newly selected field shows at once.
      if ((state_d != state_q) || (state_q == RUN)) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == 32'(BLINK_CYC - 1)) begin
         blink_cnt_d = '0;
         phase_d     = !phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 32'd1;
      end

      blank_hr_d  = phase_d && (state_d == SET_HR) && !inc_held;
      blank_min_d = phase_d && (state_d == SET_MIN) && !inc_held;
      setting_d   = (state_d != RUN);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= RUN;
         hours_q     <= '0;
         minutes_q   <= '0;
         seconds_q   <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         blank_hr_q  <= 1'b0;
         blank_min_q <= 1'b0;
         setting_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         hours_q     <= hours_d;
         minutes_q   <= minutes_d;
         seconds_q   <= seconds_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         blank_hr_q  <= blank_hr_d;
         blank_min_q <= blank_min_d;
         setting_q   <= setting_d;
      end
   end

   assign o_hours     = hours_q;
   assign o_minutes   = minutes_q;
   assign o_seconds   = seconds_q;
   assign o_blank_hr  = blank_hr_q;
   assign o_blank_min = blank_min_q;
   assign o_setting   = setting_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode_state;
   logic [1:0] inc_state;
   logic       sec_tick;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       blank_hr;
   logic       blank_min;
   logic       setting;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clock_set_ctrl #(.BLINK_CYC(4), .REPEAT_CYC(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_mode_state (mode_state),
      .i_inc_state  (inc_state),
      .i_sec_tick   (sec_tick),
      .o_hours      (hours),
      .o_minutes    (minutes),
      .o_seconds    (seconds),
      .o_blank_hr   (blank_hr),
      .o_blank_min  (blank_min),
      .o_setting    (setting)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s);
      chk({tag, ".hr"}, int'(hours), h);
      chk({tag, ".min"}, int'(minutes), m);
      chk({tag, ".sec"}, int'(seconds), s);
   endtask

   task automatic ticks(input int n);
      sec_tick = 1'b1;
      repeat (n) @(negedge clk);
      sec_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic mode_press(input logic [1:0] code);
      mode_state = code;
      repeat (3) @(negedge clk);
      mode_state = 2'b00;
      repeat (2) @(negedge clk);
   endtask

   task automatic inc_presses(input int n);
      for (int i = 0; i < n; i++) begin
         inc_state = 2'b10;
         @(negedge clk);
         inc_state = 2'b00;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   initial begin
      int bad;
      rst        = 1'b1;
      mode_state = 2'b00;
      inc_state  = 2'b00;
      sec_tick   = 1'b0;
      repeat (3) @(negedge clk);
      chk_time("reset", 0, 0, 0);
      chk("reset.setting", int'(setting), 0);
      chk("reset.blank", int'({blank_hr, blank_min}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      ticks(61);
      chk_time("run61", 0, 1, 1);

      // MODE short held 100 cycles: one transition, visible two edges later.
      mode_state = 2'b10;
      @(negedge clk);
      chk("mode.lat1", int'(setting), 0);
      @(negedge clk);
      chk("mode.lat2", int'(setting), 1);
      bad = 0;
      repeat (98) begin
         @(negedge clk);
         if (blank_min || !setting) bad++;
      end
      chk("mode.once", bad, 0);
      mode_state = 2'b00;
      repeat (2) @(negedge clk);

      inc_presses(23);
      chk_time("sethr23", 23, 1, 1);

      mode_press(2'b10);
      chk("setmin.setting", int'(setting), 1);
      inc_presses(58);
      chk_time("setmin59", 23, 59, 1);
      inc_presses(1);
      chk_time("minwrap", 23, 0, 1);
      inc_presses(59);

      ticks(5);
      chk_time("setfrozen", 23, 59, 1);

      mode_press(2'b10);
      chk("run.setting", int'(setting), 0);
      chk_time("run.secclr", 23, 59, 0);
      ticks(59);
      chk_time("pre_roll", 23, 59, 59);
      ticks(1);
      chk_time("rollover", 0, 0, 0);

      ticks(5);
      mode_press(2'b01);
      chk_time("longclr", 0, 0, 0);
      chk("longclr.setting", int'(setting), 0);

      // Enter SET_HR and check blink phase boundary.
      mode_state = 2'b10;
      repeat (2) @(negedge clk);
      chk("blink.entry", int'(blank_hr), 0);
      repeat (3) @(negedge clk);
      chk("blink.pre", int'(blank_hr), 0);
      @(negedge clk);
      chk("blink.on", int'(blank_hr), 1);
      mode_state = 2'b00;
      repeat (2) @(negedge clk);

      // Hold INC 25 cycles: increments at cycles 8, 16, 24.
      inc_state = 2'b11;
      bad = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (blank_hr) bad++;
         if (i == 8) chk("rpt.before", int'(hours), 0);
         if (i == 9) chk("rpt.first", int'(hours), 1);
      end
      chk("rpt.blank", bad, 0);
      chk("rpt.three", int'(hours), 3);
      inc_state = 2'b01;
      repeat (4) @(negedge clk);
      inc_state = 2'b00;
      repeat (2) @(negedge clk);
      chk("rpt.norelease", int'(hours), 3);

      // Simultaneous MODE and INC short: MODE wins.
      mode_state = 2'b10;
      inc_state  = 2'b10;
      repeat (2) @(negedge clk);
      chk("simul.hr", int'(hours), 3);
      chk("simul.min", int'(minutes), 0);
      repeat (3) @(negedge clk);
      chk("simul.minoff", int'(blank_min), 0);
      @(negedge clk);
      chk("simul.minon", int'(blank_min), 1);
      chk("simul.hroff", int'(blank_hr), 0);
      mode_state = 2'b00;
      inc_state  = 2'b00;
      repeat (2) @(negedge clk);

      // Reset in the middle of an auto-repeat hold in SET_MIN.
      inc_state = 2'b11;
      repeat (12) @(negedge clk);
      chk("rstrpt.min", int'(minutes), 1);
      #2 rst = 1'b1;
      #1;
      chk_time("async", 0, 0, 0);
      chk("async.setting", int'(setting), 0);
      inc_state = 2'b10;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_time("stale", 0, 0, 0);
      chk("stale.setting", int'(setting), 0);
      ticks(1);
      chk_time("postrst.tick", 0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
